// File: rtl/gcm_pkg.sv
// Shared definitions for the GCM framing blocks: block geometry, FSM encoding
// and the byte-mask builder used for the partial final block.
package gcm_pkg;

  localparam int NB_BLOCK = 128;
  localparam int N_BYTES  = NB_BLOCK / 8;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } gcm_state_e;

  // Byte 0 sits at the top of the block; nbytes of 0 or above 16 means a full block.
  function automatic logic [NB_BLOCK-1:0] byte_mask(input logic [4:0] nbytes);
    logic [NB_BLOCK-1:0] mask;
    int                  eff;
    eff  = ((nbytes == 5'd0) || (nbytes > 5'd16)) ? N_BYTES : int'(nbytes);
    mask = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      mask[NB_BLOCK-1-8*i -: 8] = (i < eff) ? 8'hff : 8'h00;
    end
    return mask;
  endfunction

endpackage

// File: rtl/gcm_last_block_mask.sv
// Zeroes every byte of a block at index >= nbytes so the final block is padded.
module gcm_last_block_mask
  import gcm_pkg::*;
(
  input  logic [NB_BLOCK-1:0] block,
  input  logic [4:0]          nbytes,
  output logic [NB_BLOCK-1:0] masked
);

  assign masked = block & byte_mask(nbytes);

endmodule

// File: rtl/gcm_block_packer.sv
// Packs 128-bit plaintext beats into N_BLOCKS-wide words for gcm_aes_cipher and
// tracks frame bit length. Optional zero padding: GCM_BLOCK_PACKER_ZERO_PAD_EN.
//
// Handshake: input beats are qualified by i_valid only (no ready; every beat is
// taken). Output words are qualified by the single-cycle o_valid strobe; the
// consumer must take every word.
module gcm_block_packer
  import gcm_pkg::*;
#(
  parameter int NB_BLOCK  = 128,
  parameter int N_BLOCKS  = 2,
  parameter int NB_DATA   = N_BLOCKS * NB_BLOCK,
  parameter int NB_LEN    = 64,
  parameter int NB_NBYTES = 5
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NB_BLOCK-1:0]  i_block,
  input  logic                 i_valid,
  input  logic                 i_sop,
  input  logic                 i_eop,
  input  logic [NB_NBYTES-1:0] i_last_nbytes,
  output logic [NB_DATA-1:0]   o_plaintext_words_x,
  output logic [N_BLOCKS-1:0]  o_block_valid,
  output logic                 o_valid,
  output logic                 o_sop,
  output logic                 o_eop,
  output logic [NB_LEN-1:0]    o_length_plaintext,
  output logic                 o_error,
  output gcm_state_e           fsm_state
);

  localparam int SLOT_W = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;

  gcm_state_e          state_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [NB_LEN-1:0]   bit_q;
  logic [NB_DATA-1:0]  buf_q;
  logic [N_BLOCKS-1:0] bv_q;
  logic                first_q;

  logic [4:0]          nbytes_eff;
  logic [NB_BLOCK-1:0] blk_in;
  logic                restart;
  logic                accept;
  logic                emit;
  logic                err;
  logic [SLOT_W-1:0]   wslot;
  logic [NB_DATA-1:0]  word_next;
  logic [N_BLOCKS-1:0] bv_next;
  logic [NB_LEN-1:0]   incr;
  logic [NB_LEN-1:0]   cnt_next;

  always_comb begin
    if ((i_last_nbytes == '0) || (i_last_nbytes > NB_NBYTES'(16))) nbytes_eff = 5'd16;
    else                                                         nbytes_eff = i_last_nbytes[4:0];
  end

`ifdef GCM_BLOCK_PACKER_ZERO_PAD_EN
  logic [NB_BLOCK-1:0] masked;

  gcm_last_block_mask u_mask (
    .block  (i_block),
    .nbytes (nbytes_eff),
    .masked (masked)
  );

  assign blk_in = i_eop ? masked : i_block;
`else
  assign blk_in = i_block;
`endif

  always_comb begin
    // A sop beat always restarts the frame, whether or not one was in progress.
    restart   = i_valid & i_sop;
    accept    = i_valid & ((state_q == FILL) | i_sop);
    err       = i_valid & ((state_q == IDLE) ? ~i_sop : i_sop);
    wslot     = restart ? '0 : slot_q;
    word_next = restart ? '0 : buf_q;
    bv_next   = restart ? '0 : bv_q;
    word_next[NB_DATA-1-int'(wslot)*NB_BLOCK -: NB_BLOCK] = blk_in;
    bv_next[N_BLOCKS-1-int'(wslot)] = 1'b1;
    incr      = i_eop ? (NB_LEN'(nbytes_eff) << 3) : NB_LEN'(NB_BLOCK);
    cnt_next  = (restart ? '0 : bit_q) + incr;
    emit      = accept & (i_eop | (wslot == SLOT_W'(N_BLOCKS-1)));
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q             <= IDLE;
      slot_q              <= '0;
      bit_q               <= '0;
      buf_q               <= '0;
      bv_q                <= '0;
      first_q             <= 1'b0;
      o_plaintext_words_x <= '0;
      o_block_valid       <= '0;
      o_valid             <= 1'b0;
      o_sop               <= 1'b0;
      o_eop               <= 1'b0;
      o_length_plaintext  <= '0;
      o_error             <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_sop   <= 1'b0;
      o_eop   <= 1'b0;
      o_error <= err;
      if (accept) begin
        bit_q <= cnt_next;
        if (emit) begin
          // Buffer is cleared on every emit so unused trailing slots read as zero.
          o_plaintext_words_x <= word_next;
          o_block_valid       <= bv_next;
          o_valid             <= 1'b1;
          o_sop               <= restart | first_q;
          o_eop               <= i_eop;
          buf_q               <= '0;
          bv_q                <= '0;
          slot_q              <= '0;
          first_q             <= 1'b0;
          if (i_eop) begin
            o_length_plaintext <= cnt_next;
            state_q            <= IDLE;
          end else begin
            state_q            <= FILL;
          end
        end else begin
          buf_q   <= word_next;
          bv_q    <= bv_next;
          slot_q  <= wslot + SLOT_W'(1);
          first_q <= restart | first_q;
          state_q <= FILL;
        end
      end
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_gcm_block_packer.sv
// Directed bench for gcm_block_packer with N_BLOCKS=2; honours
// GCM_BLOCK_PACKER_ZERO_PAD_EN when computing expected final blocks.
module tb_gcm_block_packer;
  import gcm_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] blk;
  logic         valid;
  logic         sop;
  logic         eop;
  logic [4:0]   nbytes;
  logic [255:0] word;
  logic [1:0]   bv;
  logic         o_valid;
  logic         o_sop;
  logic         o_eop;
  logic [63:0]  len;
  logic         o_error;
  gcm_state_e   st;

  int n_checks = 0;
  int n_fail   = 0;

  gcm_block_packer dut (
    .i_clock             (clk),
    .i_reset             (rst),
    .i_block             (blk),
    .i_valid             (valid),
    .i_sop               (sop),
    .i_eop               (eop),
    .i_last_nbytes       (nbytes),
    .o_plaintext_words_x (word),
    .o_block_valid       (bv),
    .o_valid             (o_valid),
    .o_sop               (o_sop),
    .o_eop               (o_eop),
    .o_length_plaintext  (len),
    .o_error             (o_error),
    .fsm_state           (st)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [127:0] b, input logic s, input logic e, input logic [4:0] nb);
    blk    = b;
    valid  = 1'b1;
    sop    = s;
    eop    = e;
    nbytes = nb;
    @(posedge clk);
    #1;
    valid  = 1'b0;
    sop    = 1'b0;
    eop    = 1'b0;
    nbytes = 5'd0;
    blk    = '0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FF = {128{1'b1}};
  localparam logic [127:0] B1 = 128'h11111111111111111111111111111111;
  localparam logic [127:0] B2 = 128'h22222222222222222222222222222222;
  localparam logic [127:0] B3 = 128'h33333333333333333333333333333333;
  localparam logic [127:0] B4 = 128'h44444444444444444444444444444444;
  localparam logic [127:0] B5 = 128'h55555555555555555555555555555555;
  localparam logic [127:0] F8 = 128'h0102030405060708090a0b0c0d0e0f10;
`ifdef GCM_BLOCK_PACKER_ZERO_PAD_EN
  localparam logic [127:0] FF_LAST = 128'hffffffff000000000000000000000000;
  localparam logic [127:0] F8_LAST = 128'h01020304050607080000000000000000;
`else
  localparam logic [127:0] FF_LAST = FF;
  localparam logic [127:0] F8_LAST = F8;
`endif

  initial begin
    rst = 1'b1; blk = '0; valid = 1'b0; sop = 1'b0; eop = 1'b0; nbytes = 5'd0;
    idle_cycle();
    idle_cycle();
    check("rst_word", word, 256'h0);
    check("rst_valid", {255'h0, o_valid}, 256'h0);
    check("rst_len", {192'h0, len}, 256'h0);
    check("rst_state", {255'h0, st}, {255'h0, IDLE});
    rst = 1'b0;
    idle_cycle();

    // Two-beat frame with full last block
    beat(A, 1'b1, 1'b0, 5'd0);
    check("t1_b1_valid", {255'h0, o_valid}, 256'h0);
    check("t1_b1_state", {255'h0, st}, {255'h0, FILL});
    beat('0, 1'b0, 1'b1, 5'd0);
    check("t1_valid", {255'h0, o_valid}, 256'h1);
    check("t1_sop_eop", {254'h0, o_sop, o_eop}, 256'h3);
    check("t1_word", word, {A, 128'h0});
    check("t1_bv", {254'h0, bv}, 256'h3);
    check("t1_len", {192'h0, len}, 256'd256);
    idle_cycle();
    check("t1_valid_pulse", {255'h0, o_valid}, 256'h0);
    check("t1_word_hold", word, {A, 128'h0});

    // Single-beat frame, 4 bytes
    beat(FF, 1'b1, 1'b1, 5'd4);
    check("t2_valid", {255'h0, o_valid}, 256'h1);
    check("t2_word", word, {FF_LAST, 128'h0});
    check("t2_bv", {254'h0, bv}, 256'h2);
    check("t2_len", {192'h0, len}, 256'd32);

    // Five-beat frame
    beat(B1, 1'b1, 1'b0, 5'd0);
    check("t3_b1_valid", {255'h0, o_valid}, 256'h0);
    beat(B2, 1'b0, 1'b0, 5'd0);
    check("t3_w1_flags", {253'h0, o_valid, o_sop, o_eop}, 256'h6);
    check("t3_w1_word", word, {B1, B2});
    beat(B3, 1'b0, 1'b0, 5'd0);
    check("t3_b3_valid", {255'h0, o_valid}, 256'h0);
    beat(B4, 1'b0, 1'b0, 5'd0);
    check("t3_w2_flags", {253'h0, o_valid, o_sop, o_eop}, 256'h4);
    check("t3_w2_word", word, {B3, B4});
    check("t3_len_hold", {192'h0, len}, 256'd32);
    beat(B5, 1'b0, 1'b1, 5'd0);
    check("t3_w3_flags", {253'h0, o_valid, o_sop, o_eop}, 256'h5);
    check("t3_w3_word", word, {B5, 128'h0});
    check("t3_w3_bv", {254'h0, bv}, 256'h2);
    check("t3_len", {192'h0, len}, 256'd640);

    // Valid without sop while idle
    beat(B3, 1'b0, 1'b0, 5'd0);
    check("t4_error", {255'h0, o_error}, 256'h1);
    check("t4_valid", {255'h0, o_valid}, 256'h0);
    check("t4_state", {255'h0, st}, {255'h0, IDLE});
    idle_cycle();
    check("t4_error_pulse", {255'h0, o_error}, 256'h0);

    // sop arriving in FILL restarts the frame
    beat(B1, 1'b1, 1'b0, 5'd0);
    check("t5_first_err", {255'h0, o_error}, 256'h0);
    beat(B2, 1'b1, 1'b0, 5'd0);
    check("t5_error", {255'h0, o_error}, 256'h1);
    check("t5_no_valid", {255'h0, o_valid}, 256'h0);
    check("t5_state", {255'h0, st}, {255'h0, FILL});
    beat(F8, 1'b0, 1'b1, 5'd8);
    check("t5_flags", {253'h0, o_valid, o_sop, o_eop}, 256'h7);
    check("t5_word", word, {B2, F8_LAST});
    check("t5_len", {192'h0, len}, 256'd192);
    check("t5_err_clear", {255'h0, o_error}, 256'h0);

    // Reset with slot 1 pending
    beat(B4, 1'b1, 1'b0, 5'd0);
    check("t6_pend_state", {255'h0, st}, {255'h0, FILL});
    rst = 1'b1;
    idle_cycle();
    rst = 1'b0;
    check("t6_rst_word", word, 256'h0);
    check("t6_rst_bv", {254'h0, bv}, 256'h0);
    check("t6_rst_pulses", {252'h0, o_valid, o_sop, o_eop, o_error}, 256'h0);
    check("t6_rst_len", {192'h0, len}, 256'h0);
    check("t6_rst_state", {255'h0, st}, {255'h0, IDLE});

    // Back-to-back frames: eop then sop on the next cycle
    beat(B1, 1'b1, 1'b0, 5'd0);
    check("t7_b1_valid", {255'h0, o_valid}, 256'h0);
    beat(B2, 1'b0, 1'b1, 5'd0);
    check("t7_f1_flags", {253'h0, o_valid, o_sop, o_eop}, 256'h7);
    check("t7_f1_word", word, {B1, B2});
    check("t7_f1_len", {192'h0, len}, 256'd256);
    beat(B5, 1'b1, 1'b1, 5'd20);
    check("t7_f2_flags", {253'h0, o_valid, o_sop, o_eop}, 256'h7);
    check("t7_f2_word", word, {B5, 128'h0});
    check("t7_f2_bv", {254'h0, bv}, 256'h2);
    check("t7_f2_len", {192'h0, len}, 256'd128);
    idle_cycle();
    check("t7_idle_valid", {255'h0, o_valid}, 256'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gcm_block_packer.md
# gcm_block_packer

Upstream framing stage for `gcm_aes_cipher`. It accepts a stream of 128-bit plaintext blocks, one per beat, delimited by start and end of frame. It packs every N_BLOCKS beats into one NB_DATA-wide word and drives the cipher's `i_plaintext_words_x`, `i_sop` and `i_valid` inputs. It also computes the plaintext bit length that the cipher needs for the tag, and handles the partial final block and malformed framing.

## Interface
Parameters:
- NB_BLOCK, 128, block width in bits
- N_BLOCKS, 2, blocks per output word
- NB_DATA, N_BLOCKS*NB_BLOCK, output word width
- NB_LEN, 64, plaintext length width (bits counted)
- NB_NBYTES, 5, width of last-beat byte count

Ports:
- i_clock  in  1  clock; single clock domain
- i_reset  in  1  synchronous, active-high reset
- i_block  in  NB_BLOCK  input block; byte 0 is bits [127:120]
- i_valid  in  1  beat qualifier
- i_sop  in  1  first beat of frame (qualified by i_valid)
- i_eop  in  1  last beat of frame (qualified by i_valid)
- i_last_nbytes  in  NB_NBYTES  valid bytes on the eop beat, 1..16; 0 means 16
- o_plaintext_words_x  out  NB_DATA  packed word; block k at bits [NB_DATA-1-k*128 -: 128]
- o_block_valid  out  N_BLOCKS  bit k set when block k carries frame data
- o_valid  out  1  word strobe, to cipher i_valid
- o_sop  out  1  first word of frame, to cipher i_sop
- o_eop  out  1  last word of frame
- o_length_plaintext  out  NB_LEN  frame length in bits
- o_error  out  1  one-cycle framing-error pulse

## Operation
- FSM has two states: IDLE and FILL. A slot counter runs 0..N_BLOCKS-1 and a bit counter is NB_LEN wide.
- **IDLE**
  - A beat with i_valid&i_sop writes i_block into slot 0. The bit counter loads 128, or 8*nbytes if eop is also set.
  - Go to FILL, or emit immediately if eop or N_BLOCKS==1.
  - A beat with i_valid&!i_sop is dropped and pulses o_error.
- **FILL**
  - Each valid beat writes the next slot and adds 128 to the bit counter, or 8*nbytes on eop.
  - When the slot counter reaches N_BLOCKS-1, or on eop, register the word and assert o_valid; the slot counter returns to 0.
  - Eop returns the FSM to IDLE. Otherwise it stays in FILL.
- The first emitted word of a frame carries o_sop=1.
- Eop word:
  - Slots after the eop slot are zero and their o_block_valid bits are 0.
  - o_eop=1, and o_length_plaintext is updated to the final bit count.
  - o_length_plaintext holds until the next eop word.
- i_sop seen in FILL:
  - Pulse o_error and discard the partial word; no o_valid is emitted for it.
  - Restart the frame with this beat as slot 0, with the same handling as in IDLE.
- The bit counter wraps modulo 2^NB_LEN.
- i_last_nbytes > 16 is treated as 16.

## Timing
- Latency is 1 cycle. Outputs are registered in the cycle after the completing beat.
- o_valid, o_sop, o_eop and o_error are single-cycle pulses.
- o_plaintext_words_x and o_block_valid hold their value between strobes.
- The block accepts one beat per cycle with no backpressure; the cipher consumes every word.
- Back-to-back frames (eop followed by sop on the next cycle) are supported with no bubble.
- Reset (i_reset=1 at a clock edge):
  - Every output goes to 0.
  - FSM goes to IDLE; slot counter and bit counter go to 0.
  - A frame in progress is discarded silently, with no o_error.
- Beats with i_valid=0 leave all state unchanged.

## Configuration
- Macro: `GCM_BLOCK_PACKER_ZERO_PAD_EN`.
- Defined: on the eop beat, bytes at index ≥ nbytes are forced to 0 before storage, so GHASH sees a zero-padded final block.
- Undefined: the eop block is stored unmodified. o_length_plaintext is still exact, and the downstream stage must mask.

## Structure
- The shared package `gcm_pkg` holds:
  - NB_BLOCK and the derived byte count (16)
  - the FSM state encoding (IDLE, FILL)
  - a function that builds the 128-bit byte mask from nbytes
- One sub-module, `gcm_last_block_mask`, is combinational. It takes a block and nbytes and returns the masked block. It is instantiated only under the macro.

## Test plan
- **Two-beat frame, N_BLOCKS=2**
  - Beat 1: 00112233445566778899aabbccddeeff with sop.
  - Beat 2: zeros with eop, nbytes=0.
  - Expect one o_valid with o_sop=o_eop=1, word {00112233…eeff, 0}, o_block_valid=2'b11, length=256.
- **Single-beat frame**
  - One beat of ff…ff with sop, eop and nbytes=4, macro defined.
  - Expect word {ffffffff000000000000000000000000, 128'h0}, o_block_valid=2'b10, length=32.
  - With the macro undefined, block 0 stays ff…ff.
- **Five-beat frame**
  - Expect three o_valid strobes. o_sop is set on the first only and o_eop on the third.
  - The third word has o_block_valid=2'b10, length=640.
- **Valid without sop in IDLE**
  - Expect o_error pulse, no o_valid, state stays IDLE.
- **sop in FILL after one beat**
  - Expect o_error pulse and the partial word dropped.
  - The new frame's first word carries o_sop=1, and its length counts only the new beats.
- **Reset mid-frame, then a back-to-back frame**
  - Assert i_reset with slot 1 pending: all outputs go to 0 and no o_error fires.
  - Then drive eop immediately followed by sop: two consecutive o_valid cycles, each with the correct o_sop and o_eop.
